// File: rtl/fp_deconvert.sv
// IEEE-754 single-precision to signed fixed-point converter, 3-stage pipeline with global stall.
// Rounds to nearest-even, saturates on overflow/infinity and flags NaN.
module fp_deconvert #(
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iVALID,
  output logic                 oREADY,
  input  logic [31:0]          iDATA,
  output logic                 oVALID,
  input  logic                 iREADY,
  output logic [OUT_WIDTH-1:0] oDATA,
  output logic                 oOVF,
  output logic                 oNAN
);

  // One spare bit above the result width holds 2^(OUT_WIDTH-1) and rounding carries.
  localparam int unsigned MagW = OUT_WIDTH + 1;
  localparam logic [MagW-1:0] HalfRange = {2'b01, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] MaxPos = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MinNeg = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic advance;
  assign advance = !oVALID || iREADY;
  assign oREADY  = advance;

  // Stage 1: decode
  logic [7:0]        inExp;
  logic [22:0]       inMant;
  logic              dZero, dInf, dNan;
  logic signed [9:0] dShift;

  always_comb begin
    inExp  = iDATA[30:23];
    inMant = iDATA[22:0];
    dZero  = (inExp == 8'h00);
    dInf   = (inExp == 8'hFF) && (inMant == 23'd0);
    dNan   = (inExp == 8'hFF) && (inMant != 23'd0);
    dShift = $signed({2'b00, inExp}) - 10'sd150 + $signed(10'(FRAC_BITS));
  end

  logic              s1Valid, s1Sign, s1Zero, s1Inf, s1Nan;
  logic [23:0]       s1Sig;
  logic signed [9:0] s1Shift;

  // Stage 2: align
  logic [MagW-1:0]   aMag;
  logic              aGuard, aRound, aSticky, aOvf;
  logic [63:0]       wideR;
  logic [5:0]        rAmt;
  logic signed [9:0] negShift;

  always_comb begin
    aMag     = '0;
    aGuard   = 1'b0;
    aRound   = 1'b0;
    aSticky  = 1'b0;
    aOvf     = 1'b0;
    wideR    = '0;
    rAmt     = '0;
    negShift = -s1Shift;
    if (s1Zero || s1Nan) begin
      aOvf = 1'b0;
    end else if (s1Inf) begin
      aOvf = 1'b1;
    end else if ($signed(10'd23) + s1Shift >= $signed(10'(OUT_WIDTH))) begin
      // Leading one lands at or above OUT_WIDTH: too large for any sign.
      aOvf = 1'b1;
    end else if (!s1Shift[9]) begin
      aMag = MagW'(s1Sig) << s1Shift[5:0];
    end else begin
      // Shifts beyond 60 leave the significand entirely in the sticky field.
      rAmt    = (negShift > 10'sd60) ? 6'd60 : negShift[5:0];
      wideR   = {s1Sig, 40'b0} >> rAmt;
      aMag    = MagW'(wideR[63:40]);
      aGuard  = wideR[39];
      aRound  = wideR[38];
      aSticky = |wideR[37:0];
    end
  end

  logic            s2Valid, s2Sign, s2Nan, s2Ovf;
  logic [MagW-1:0] s2Mag;
  logic            s2Guard, s2Round, s2Sticky;

  // Stage 3: round, negate, saturate
  logic                 roundUp, sat;
  logic [MagW-1:0]      rounded;
  logic [OUT_WIDTH-1:0] magLow, fData;
  logic                 fOvf;

  always_comb begin
    roundUp = s2Guard && (s2Round || s2Sticky || s2Mag[0]);
    rounded = s2Mag + MagW'(roundUp);
    magLow  = rounded[OUT_WIDTH-1:0];
    // Magnitude 2^(OUT_WIDTH-1) is only representable when negative.
    sat     = s2Ovf || (s2Sign ? (rounded > HalfRange) : (rounded >= HalfRange));
    fData   = '0;
    fOvf    = 1'b0;
    if (s2Nan) begin
      fData = '0;
    end else if (sat) begin
      fData = s2Sign ? MinNeg : MaxPos;
      fOvf  = 1'b1;
    end else begin
      fData = s2Sign ? -magLow : magLow;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1Valid  <= 1'b0;
      s1Sign   <= 1'b0;
      s1Zero   <= 1'b0;
      s1Inf    <= 1'b0;
      s1Nan    <= 1'b0;
      s1Sig    <= '0;
      s1Shift  <= '0;
      s2Valid  <= 1'b0;
      s2Sign   <= 1'b0;
      s2Nan    <= 1'b0;
      s2Ovf    <= 1'b0;
      s2Mag    <= '0;
      s2Guard  <= 1'b0;
      s2Round  <= 1'b0;
      s2Sticky <= 1'b0;
      oVALID   <= 1'b0;
      oDATA    <= '0;
      oOVF     <= 1'b0;
      oNAN     <= 1'b0;
    end else if (advance) begin
      s1Valid  <= iVALID;
      s1Sign   <= iDATA[31];
      s1Zero   <= dZero;
      s1Inf    <= dInf;
      s1Nan    <= dNan;
      s1Sig    <= {1'b1, inMant};
      s1Shift  <= dShift;
      s2Valid  <= s1Valid;
      s2Sign   <= s1Sign;
      s2Nan    <= s1Nan;
      s2Ovf    <= aOvf;
      s2Mag    <= aMag;
      s2Guard  <= aGuard;
      s2Round  <= aRound;
      s2Sticky <= aSticky;
      oVALID   <= s2Valid;
      oDATA    <= fData;
      oOVF     <= fOvf;
      oNAN     <= s2Nan;
    end
  end

endmodule

// File: tb/tb_fp_deconvert.sv
// Bench for fp_deconvert: two instances (32.0 and 16.8 formats) checked against an arithmetic
// model through per-instance scoreboards, plus hand-computed vectors that pin the model.
module tb_fp_deconvert;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic        iRST;
  logic        vA, rdyA, oVA, oRA, oOA, oNA;
  logic [31:0] dA, oDA;
  logic        vB, rdyB, oVB, oRB, oOB, oNB;
  logic [31:0] dB;
  logic [15:0] oDB;

  fp_deconvert #(.OUT_WIDTH(32), .FRAC_BITS(0)) dutA (
    .iCLK(iCLK), .iRST(iRST), .iVALID(vA), .oREADY(oRA), .iDATA(dA),
    .oVALID(oVA), .iREADY(rdyA), .oDATA(oDA), .oOVF(oOA), .oNAN(oNA)
  );

  fp_deconvert #(.OUT_WIDTH(16), .FRAC_BITS(8)) dutB (
    .iCLK(iCLK), .iRST(iRST), .iVALID(vB), .oREADY(oRB), .iDATA(dB),
    .oVALID(oVB), .iREADY(rdyB), .oDATA(oDB), .oOVF(oOB), .oNAN(oNB)
  );

  typedef struct {
    logic [31:0] data;
    bit          ovf;
    bit          nan;
    int          stamp;
    bit          lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] f;
    logic [31:0] d;
    bit          o;
    bit          n;
  } vec_t;

  exp_t qA[$];
  exp_t qB[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chkEn = 0;
  bit   latMode = 0;
  bit   bpMode = 0;
  int   bpIdx = 0;
  bit   holdP[2];
  bit   bpPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  vec_t vecA[16] = '{
    '{32'h3F800000, 32'h00000001, 1'b0, 1'b0},
    '{32'h40200000, 32'h00000002, 1'b0, 1'b0},
    '{32'h40600000, 32'h00000004, 1'b0, 1'b0},
    '{32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{32'hCF000000, 32'h80000000, 1'b0, 1'b0},
    '{32'hFF800000, 32'h80000000, 1'b1, 1'b0},
    '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{32'h7FC00000, 32'h00000000, 1'b0, 1'b1},
    '{32'h00000001, 32'h00000000, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000000, 1'b0, 1'b0},
    '{32'h3EFFFFFF, 32'h00000000, 1'b0, 1'b0},
    '{32'h3F000000, 32'h00000000, 1'b0, 1'b0},
    '{32'h3FC00000, 32'h00000002, 1'b0, 1'b0},
    '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0},
    '{32'h3F400000, 32'h00000001, 1'b0, 1'b0}
  };

  vec_t vecB[10] = '{
    '{32'h3FC00000, 32'h00000180, 1'b0, 1'b0},
    '{32'h3B800000, 32'h00000001, 1'b0, 1'b0},
    '{32'h3B000000, 32'h00000000, 1'b0, 1'b0},
    '{32'h3B400000, 32'h00000001, 1'b0, 1'b0},
    '{32'h43000000, 32'h00007FFF, 1'b1, 1'b0},
    '{32'hC3000000, 32'h00008000, 1'b0, 1'b0},
    '{32'h42FFFFFF, 32'h00007FFF, 1'b1, 1'b0},
    '{32'hBF800000, 32'h0000FF00, 1'b0, 1'b0},
    '{32'hC3010000, 32'h00008000, 1'b1, 1'b0},
    '{32'h7FC00001, 32'h00000000, 1'b0, 1'b1}
  };

  logic [31:0] bpVals[10] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
    32'hC0C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'hC1200000
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Exact value = sig * 2^(exp-150+fb); round by comparing the remainder with one half.
  function automatic void model(input logic [31:0] f, input int w, input int fb,
                                output logic [31:0] data, output bit ovf, output bit nan);
    int     e, s, n;
    longint sig, mag, q, r, half, hi, lo, v;
    e   = int'(f[30:23]);
    sig = longint'({1'b1, f[22:0]});
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    ovf = 0;
    nan = 0;
    v   = 0;
    mag = 0;
    if (e == 255 && f[22:0] != 0) begin
      nan = 1;
    end else if (e == 255) begin
      v = f[31] ? lo - 1 : hi + 1;
    end else if (e != 0) begin
      s = e - 150 + fb;
      if (s > 32) begin
        mag = longint'(1) <<< 60;
      end else if (s >= 0) begin
        mag = sig <<< s;
      end else begin
        n = -s;
        if (n < 26) begin
          q    = sig >>> n;
          r    = sig - (q <<< n);
          half = longint'(1) <<< (n - 1);
          mag  = q;
          if (r > half || (r == half && q % 2 == 1)) mag = q + 1;
        end
      end
      v = f[31] ? -mag : mag;
    end
    if (v > hi) begin
      v   = hi;
      ovf = 1;
    end else if (v < lo) begin
      v   = lo;
      ovf = 1;
    end
    data = 32'(v);
    if (w < 32) data = data & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic score(input int id, input bit ov, input bit orr, input bit ir,
                       input logic [31:0] od, input bit ovf, input bit nan);
    exp_t  e;
    bit    have;
    string tag;
    tag = (id == 0) ? "A" : "B";
    check({tag, ".oREADY"}, 32'(orr), 32'(!ov || ir));
    if (holdP[id]) check({tag, ".holdValid"}, 32'(ov), 32'd1);
    if (ov) begin
      if (id == 0) have = qA.size() > 0;
      else         have = qB.size() > 0;
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL %s.stale actual=%h required=no output", tag, od);
      end else begin
        if (id == 0) e = qA[0];
        else         e = qB[0];
        check({tag, ".oDATA"}, od, e.data);
        check({tag, ".flags"}, {30'd0, ovf, nan}, {30'd0, e.ovf, e.nan});
        if (ir) begin
          if (e.lat) check({tag, ".latency"}, 32'(cyc - e.stamp), 32'd3);
          if (id == 0) void'(qA.pop_front());
          else         void'(qB.pop_front());
        end
      end
    end
    holdP[id] = ov && !ir;
  endtask

  // Single compare process; accepted inputs are pushed into the scoreboards here as well.
  always @(negedge iCLK) begin
    exp_t ne;
    if (chkEn) begin
      score(0, oVA, oRA, rdyA, oDA, oOA, oNA);
      score(1, oVB, oRB, rdyB, {16'h0, oDB}, oOB, oNB);
      if (iRST) begin
        qA.delete();
        qB.delete();
        holdP[0] = 0;
        holdP[1] = 0;
      end else begin
        if (vA && oRA) begin
          model(dA, 32, 0, ne.data, ne.ovf, ne.nan);
          ne.stamp = cyc;
          ne.lat   = latMode;
          qA.push_back(ne);
        end
        if (vB && oRB) begin
          model(dB, 16, 8, ne.data, ne.ovf, ne.nan);
          ne.stamp = cyc;
          ne.lat   = latMode;
          qB.push_back(ne);
        end
      end
    end
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge iCLK);
    #1;
    if (bpMode) begin
      rdyA  = bpPat[bpIdx % 4];
      bpIdx++;
    end
  endtask

  task automatic send(input int id, input logic [31:0] d);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    if (id == 0) begin vA = 1; dA = d; end
    else         begin vB = 1; dB = d; end
    while (!acc && n < 50) begin
      @(negedge iCLK);
      acc = (id == 0) ? oRA : oRB;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send.timeout actual=not accepted required=accepted within 50 cycles");
    end
    vA = 0;
    vB = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      errors++;
      $display("FAIL drain.timeout actual=%0d/%0d pending required=0", qA.size(), qB.size());
    end
  endtask

  task automatic pin(input string name, input vec_t v, input int w, input int fb);
    logic [31:0] d;
    bit          o, n;
    model(v.f, w, fb, d, o, n);
    check({name, ".data"}, d, v.d);
    check({name, ".flags"}, {30'd0, o, n}, {30'd0, v.o, v.n});
  endtask

  initial begin
    iRST = 1;
    vA = 0; vB = 0; dA = '0; dB = '0; rdyA = 1; rdyB = 1;
    holdP[0] = 0;
    holdP[1] = 0;
    repeat (2) @(posedge iCLK);
    #1;
    chkEn = 1;
    check("rst.A.oVALID", 32'(oVA), 32'd0);
    check("rst.A.oDATA", oDA, 32'd0);
    check("rst.A.flags", {30'd0, oOA, oNA}, 32'd0);
    check("rst.B.oVALID", 32'(oVB), 32'd0);
    check("rst.B.oDATA", {16'h0, oDB}, 32'd0);
    check("rst.B.flags", {30'd0, oOB, oNB}, 32'd0);
    iRST = 0;
    tick();

    foreach (vecA[i]) pin($sformatf("pinA%0d", i), vecA[i], 32, 0);
    foreach (vecB[i]) pin($sformatf("pinB%0d", i), vecB[i], 16, 8);

    // Directed vectors, back-to-back with no stall: fixed 3-cycle latency.
    latMode = 1;
    foreach (vecA[i]) send(0, vecA[i].f);
    drain();
    foreach (vecB[i]) send(1, vecB[i].f);
    drain();

    // Backpressure: iREADY follows 1,0,0,1,... while ten values stream in.
    latMode = 0;
    bpMode  = 1;
    bpIdx   = 0;
    foreach (bpVals[i]) send(0, bpVals[i]);
    drain();
    bpMode = 0;
    rdyA   = 1;
    tick();

    // Reset with items in flight discards them; the next item has normal latency.
    latMode = 1;
    send(0, 32'h3F800000);
    send(0, 32'h40000000);
    send(0, 32'h40400000);
    iRST = 1;
    tick();
    iRST = 0;
    check("rstFlush.oVALID", 32'(oVA), 32'd0);
    send(0, 32'hC0800000);
    drain();
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_deconvert.md
Name: fp_deconvert

Overview:
- Pipelined IEEE-754 single-precision to signed fixed-point converter: the inverse of the int-to-float conversion at the neuron input.
- Sits at the output of the perceptron datapath. Turns float neuron and activation results back into two's-complement integers for the host and LED/debug logic.
- Valid/ready streaming interface with a global pipeline stall. Handles round-to-nearest-even, saturation, and special-value flags.

Parameters:
- OUT_WIDTH, 32, width of the signed fixed-point result; legal range 8..32.
- FRAC_BITS, 0, number of fractional bits in the result; legal range 0..OUT_WIDTH-2.

Ports:
- iCLK  input  1  clock; all state updates on rising edge.
- iRST  input  1  synchronous reset, active-high.
- iVALID  input  1  iDATA holds a valid float this cycle.
- oREADY  output  1  converter accepts iDATA this cycle.
- iDATA  input  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] mantissa.
- oVALID  output  1  oDATA, oOVF and oNAN are valid.
- iREADY  input  1  downstream accepts the output this cycle.
- oDATA  output  OUT_WIDTH  signed result; value = oDATA / 2^FRAC_BITS.
- oOVF  output  1  result saturated (input magnitude too large, or infinity).
- oNAN  output  1  input was a NaN.

Behaviour:
- Interface and reset:
  - Single clock iCLK. Reset iRST is synchronous and active-high.
  - On reset: all three stage valid bits clear; oVALID=0, oDATA=0, oOVF=0, oNAN=0.
  - Reset asserted mid-operation discards all in-flight items; no output for them ever appears.
- Pipeline: 3 stages; latency 3 cycles with no stall.
  - S1 decode: classify zero, denormal, infinity, NaN, normal; form 24-bit significand {1,mant}; compute shift = exp - 127 + FRAC_BITS - 23 (signed 10-bit).
  - S2 align: shift the significand left or right. On right shifts, keep guard bit, round bit, and sticky (OR of all lower bits). Detect overflow when the magnitude bit position is at or above OUT_WIDTH.
  - S3 round and finish: apply RNE (increment if guard & (round | sticky | lsb)), negate if sign=1, then saturate.
- Handshake:
  - advance = !oVALID | iREADY. oREADY = advance.
  - All stages shift only when advance=1. Input is accepted when iVALID & oREADY.
  - Bubbles are not compressed (global stall).
  - oDATA, oOVF and oNAN stay stable while oVALID=1 and iREADY=0.
- Arithmetic rules:
  - Zero and denormal inputs (exp=0) produce 0 with no flags. Denormals are flushed; -0 gives 0.
  - Representable range is -2^(OUT_WIDTH-1) .. 2^(OUT_WIDTH-1)-1.
  - Overflow positive gives 2^(OUT_WIDTH-1)-1; overflow negative gives -2^(OUT_WIDTH-1); both set oOVF=1.
  - Exactly -2^(OUT_WIDTH-1) is representable: no overflow, oOVF=0.
  - A rounding carry that exceeds the range saturates and sets oOVF.
  - Infinity (exp=255, mant=0) saturates by sign with oOVF=1.
  - NaN (exp=255, mant!=0) gives oDATA=0, oNAN=1, oOVF=0.
  - Right shifts of 25 or more give 0 before rounding, except that the sticky bit is kept. Result is 0 with no flags.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both legal; full throughput is 1 item per cycle.
  - iRST takes priority over everything else.

Test Plan:
- OUT_WIDTH=32, FRAC_BITS=0; iREADY=1; send 0x3F800000, 0x40200000, 0x40600000, 0xBFC00000 on consecutive cycles -> results 1, 2, 4, -2. Each appears exactly 3 cycles after acceptance, back-to-back, with flags 0.
- Send 0x4F000000 (2^31) -> 0x7FFFFFFF, oOVF=1. Send 0xCF000000 (-2^31) -> 0x80000000, oOVF=0. Send 0xFF800000 (-inf) -> 0x80000000, oOVF=1.
- Send 0x7FC00000 (NaN) -> oDATA=0, oNAN=1. Send 0x00000001 (denormal) and 0x80000000 (-0) -> 0 with no flags. Send 0x3EFFFFFF (≈0.5-) -> 0.
- FRAC_BITS=8, OUT_WIDTH=16: send 0x3FC00000 (1.5) -> 0x0180. Send 0x3B800000 (2^-8) -> 0x0001. Send 0x3B000000 (2^-9, tie) -> 0x0000 (RNE).
- Backpressure: stream 10 values with iREADY toggling 1,0,0,1,… -> every value is output exactly once, in order, and held stable while stalled. oREADY=0 exactly when oVALID=1 and iREADY=0.
- Pulse iRST for 1 cycle with 3 items in flight -> oVALID=0 the next cycle and no stale outputs afterwards. The first item sent after reset emerges 3 cycles after acceptance.
